// File: rtl/cart_pkg.sv
// rtl/cart_pkg.sv - shared types and constants for the cartridge bank-switch mapper
// Purpose: mapper encoding, hotspot windows, reset banks and Superchip windows.
// Ports: none (package).
package cart_pkg;

  typedef enum logic [2:0] {
    MAP_NONE = 3'd0,
    MAP_F8   = 3'd1,
    MAP_F6   = 3'd2,
    MAP_F4   = 3'd3,
    MAP_E0   = 3'd4
  } mapper_e;

  // Superchip RAM address width (128 bytes)
  localparam int SC_AW = 7;

  // Hotspot windows, compared against cpu_a[11:0]
  localparam logic [11:0] F8_HS_LO = 12'hFF8;
  localparam logic [11:0] F8_HS_HI = 12'hFF9;
  localparam logic [11:0] F6_HS_LO = 12'hFF6;
  localparam logic [11:0] F6_HS_HI = 12'hFF9;
  localparam logic [11:0] F4_HS_LO = 12'hFF4;
  localparam logic [11:0] F4_HS_HI = 12'hFFB;
  localparam logic [11:0] E0_HS_LO = 12'hFE0;
  localparam logic [11:0] E0_HS_HI = 12'hFF7;

  // Bank values after reset or reconfiguration
  localparam logic       F8_RST_BANK = 1'b1;
  localparam logic [1:0] F6_RST_BANK = 2'd3;
  localparam logic [2:0] F4_RST_BANK = 3'd7;
  localparam logic [2:0] E0_RST_S0   = 3'd4;
  localparam logic [2:0] E0_RST_S1   = 3'd5;
  localparam logic [2:0] E0_RST_S2   = 3'd6;
  localparam logic [2:0] E0_FIXED_S3 = 3'd7;

  // Superchip windows, selected by cpu_a[11:7]
  localparam logic [4:0] SC_WR_PAGE = 5'b00000; // $000-$07F
  localparam logic [4:0] SC_RD_PAGE = 5'b00001; // $080-$0FF

  // Codes 5-7 behave as an unbanked cartridge
  function automatic mapper_e decode_mapper(input logic [2:0] m);
    case (m)
      3'd1:    return MAP_F8;
      3'd2:    return MAP_F6;
      3'd3:    return MAP_F4;
      3'd4:    return MAP_E0;
      default: return MAP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cart_sc_ram.sv
// rtl/cart_sc_ram.sv - Superchip 128x8 synchronous single-port RAM
// Purpose: byte RAM with synchronous write and registered read; contents not reset.
// Ports: clk; we write enable; addr byte address; wdata write byte; rdata registered read byte.
module sc_ram
  import cart_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             we,
  input  logic [SC_AW-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cart_mapper.sv
// rtl/cart_mapper.sv - cartridge bank-switch controller (F8/F6/F4/E0 + Superchip)
// Purpose: maps 6507 addresses to a flat ROM address, tracks hotspot bank switches,
//          and serves Superchip RAM reads.
// Ports: clk, rst (async, active high); ce end-of-bus-cycle strobe; mapper type;
//        sc_en Superchip enable; cpu_a/cpu_rw/cpu_do CPU bus; cpu_di read data out;
//        rom_addr flat ROM address (combinational); rom_data ROM byte (1 clk latency).
module cart_mapper
  import cart_pkg::*;
#(
  parameter int ROM_AW   = 15,
  parameter int SC_DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [2:0]        mapper,
  input  logic              sc_en,
  input  logic [12:0]       cpu_a,
  input  logic              cpu_rw,
  input  logic [7:0]        cpu_do,
  output logic [7:0]        cpu_di,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data
);

  mapper_e     map_e;
  logic        sel;
  logic [11:0] off;
  logic [11:0] d_f6;
  logic [11:0] d_f4;

  logic        bank_f8;
  logic [1:0]  bank_f6;
  logic [2:0]  bank_f4;
  logic [2:0]  e0_s0, e0_s1, e0_s2;

  logic [3:0]  cfg_q;
  logic        cfg_ok;
  logic        cfg_change;
  logic        hs_ev;

  logic [2:0]  e0_bank;
  logic [14:0] addr15;
  logic        sc_rd_hit;
  logic        sc_we;
  logic [7:0]  ram_q;

  assign map_e = decode_mapper(mapper);
  assign sel   = cpu_a[12];
  assign off   = cpu_a[11:0];
  assign d_f6  = off - F6_HS_LO;
  assign d_f4  = off - F4_HS_LO;
  assign hs_ev = ce && sel;

  // cfg_ok is cleared by reset so the first edge after release always reloads
  // the banks; this also swallows a ce that coincides with reset release.
  assign cfg_change = !cfg_ok || (cfg_q != {mapper, sc_en});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q   <= 4'd0;
      cfg_ok  <= 1'b0;
      bank_f8 <= F8_RST_BANK;
      bank_f6 <= F6_RST_BANK;
      bank_f4 <= F4_RST_BANK;
      e0_s0   <= E0_RST_S0;
      e0_s1   <= E0_RST_S1;
      e0_s2   <= E0_RST_S2;
    end else begin
      cfg_q  <= {mapper, sc_en};
      cfg_ok <= 1'b1;
      if (cfg_change) begin
        bank_f8 <= F8_RST_BANK;
        bank_f6 <= F6_RST_BANK;
        bank_f4 <= F4_RST_BANK;
        e0_s0   <= E0_RST_S0;
        e0_s1   <= E0_RST_S1;
        e0_s2   <= E0_RST_S2;
      end else if (hs_ev) begin
        case (map_e)
          MAP_F8: if (off == F8_HS_LO || off == F8_HS_HI) bank_f8 <= off[0];
          MAP_F6: if (off >= F6_HS_LO && off <= F6_HS_HI) bank_f6 <= d_f6[1:0];
          MAP_F4: if (off >= F4_HS_LO && off <= F4_HS_HI) bank_f4 <= d_f4[2:0];
          MAP_E0: begin
            // Within $FE0-$FF7, cpu_a[4:3] only ever names slices 0..2
            if (off >= E0_HS_LO && off <= E0_HS_HI) begin
              case (off[4:3])
                2'd0:    e0_s0 <= off[2:0];
                2'd1:    e0_s1 <= off[2:0];
                default: e0_s2 <= off[2:0];
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    e0_bank = E0_FIXED_S3;
    case (cpu_a[11:10])
      2'd0:    e0_bank = e0_s0;
      2'd1:    e0_bank = e0_s1;
      2'd2:    e0_bank = e0_s2;
      default: e0_bank = E0_FIXED_S3;
    endcase

    addr15 = {3'b000, off};
    case (map_e)
      MAP_F8:  addr15 = {2'b00, bank_f8, off};
      MAP_F6:  addr15 = {1'b0, bank_f6, off};
      MAP_F4:  addr15 = {bank_f4, off};
      MAP_E0:  addr15 = {2'b00, e0_bank, cpu_a[9:0]};
      default: addr15 = {3'b000, off};
    endcase
  end

  assign rom_addr = ROM_AW'(addr15);

  assign sc_rd_hit = sc_en && sel && cpu_rw && (off[11:7] == SC_RD_PAGE);
  assign sc_we     = ce && sc_en && sel && !cpu_rw && (off[11:7] == SC_WR_PAGE);

  sc_ram #(
    .DEPTH (SC_DEPTH)
  ) u_sc_ram (
    .clk   (clk),
    .we    (sc_we),
    .addr  (cpu_a[6:0]),
    .wdata (cpu_do),
    .rdata (ram_q)
  );

  assign cpu_di = !sel      ? 8'hFF :
                  sc_rd_hit ? ram_q : rom_data;

endmodule

// File: doc/cart_mapper.md
Name: cart_mapper

Overview:
- Cartridge-side bank-switch controller directly downstream of the 2600 system block.
- Consumes the 6507 bus (13-bit address, R/W, write data, phi0 strobe) and returns read data on the system's external data input.
- Translates CPU addresses into a 15-bit flat ROM address.
- Implements F8/F6/F4/E0 hotspot banking and optional Superchip (128 B) RAM.

Parameters:
- ROM_AW, 15, flat ROM address width (32 KiB max image).
- SC_DEPTH, 128, Superchip RAM bytes.

Ports:
- clk  in  1  system clock (3.58 MHz domain of the console).
- rst  in  1  asynchronous active-high reset.
- ce  in  1  one-clk phi0 strobe marking end of a CPU bus cycle; pulses spaced ≥3 clk.
- mapper  in  3  0=none (2K/4K), 1=F8, 2=F6, 3=F4, 4=E0; 5-7 treated as 0.
- sc_en  in  1  Superchip RAM enable.
- cpu_a  in  13  CPU address.
- cpu_rw  in  1  1=read, 0=write.
- cpu_do  in  8  CPU write data.
- cpu_di  out  8  read data to system (ANDed there with TIA/RIOT).
- rom_addr  out  15  ROM byte address, combinational.
- rom_data  in  8  ROM data, valid 1 clk after rom_addr.

Behaviour:
Address decode and read path:
- Cart selected when cpu_a[12]=1. When not selected, cpu_di=8'hFF, and no bank or RAM effects.
- rom_addr, combinational, per mapper:
  - none: cpu_a[11:0].
  - F8/F6/F4: {bank, cpu_a[11:0]}, with bank zero-extended to 3 bits.
  - E0: {slice_bank[cpu_a[11:10]], cpu_a[9:0]}; slice 3 is fixed at bank 7.
- cpu_di = rom_data when selected and not an SC read. The address must be stable ≥2 clk before ce; this is met by ce spacing.

Hotspots:
- Evaluated only on clk edges where ce=1 and cpu_a[12]=1, for reads and writes alike. Only cpu_a[11:0] is compared.
- F8: $FF8→bank 0, $FF9→1.
- F6: $FF6..$FF9→0..3.
- F4: $FFF4..$FFFB→0..7.
- E0: $FE0..$FF7: slice=cpu_a[4:3] (0..2), slice_bank[slice]=cpu_a[2:0].
- New bank is registered at that edge and takes effect from the next cycle's rom_addr. The hotspot access itself returns data from the old bank.
- An address held across several clk with a single ce switches exactly once. Without ce nothing changes.

Superchip (sc_en=1):
- Write port $000-$07F (offset): on ce with cpu_rw=0, ram[cpu_a[6:0]] <= cpu_do.
- Read port $080-$0FF: cpu_di = ram_q, where ram_q is registered each clk from cpu_a[6:0] (1-clk latency).
- Write to the read port: ignored. Read of the write port: returns rom_data, no RAM write.
- RAM contents are not reset. Hotspot and SC windows never overlap.

Reset and reconfiguration values:
- F8 bank=1, F6 bank=3, F4 bank=7. E0 slice_bank={4,5,6} for slices 0..2.
- mapper and sc_en are quasi-static. A registered copy is compared every clk; any change reloads the reset bank values on the next clk.
- rst mid-cycle returns banks to reset values immediately (async). A ce coincident with the reset release is ignored.

Outputs at reset:
- rom_addr reflects reset banks.
- cpu_di follows the decode rules; it is 8'hFF when cpu_a[12]=0.

Decomposition:
- Shared package cart_pkg holds:
  - mapper enum (MAP_NONE, MAP_F8, MAP_F6, MAP_F4, MAP_E0);
  - hotspot base/limit constants;
  - reset bank constants;
  - SC window constants.
- One sub-module, sc_ram: 128x8 synchronous single-port RAM (write on we, registered read).
- Decode and bank registers stay in cart_mapper.

Test Plan:
- F8 bank switch: mapper=1, reset; read $1FFC → rom_addr=$1FFC. Read $1FF8 with ce → next read $1000 gives rom_addr=$0000. Then write $1FF9 → rom_addr=$1000.
- F4 full range: mapper=3; ce at $1FF4..$1FFB in turn, each followed by a read of $1123. Required rom_addr = {k,$123} for k=0..7. Holding $1FF5 for 9 clk with one ce gives a single switch.
- E0 slices: mapper=4; ce at $1FE9 (slice1←1), $1FF2 (slice2←2).
  - $1400→rom_addr $0400 (slice1, bank1).
  - $1800→$0800 (slice2, bank2).
  - $1000→$1000 (slice0, bank4).
  - $1C05→$1C05 (slice3, bank7).
- Superchip: sc_en=1, F8; write $A5 to $1010 with ce; read $1090 → cpu_di=$A5. Write $3C to $1090 → RAM unchanged. sc_en=0 → $1090 returns rom_data.
- Non-cart isolation: F6 bank 3; ce at $0FF6 (cpu_a[12]=0) → bank stays 3, cpu_di=$FF.
- Reset/reconfig: F6 switched to bank 1. Assert rst between ce pulses → rom_addr for $1000 becomes $3000. Change mapper 2→1 without rst → bank=1 next clk.
